// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: chunk sizing and the width/stage split check.
package adder_pkg;

    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? width / stages : 0;
    endfunction

    function automatic bit split_ok(input int width, input int stages);
        return (stages > 0) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational N-bit ripple adder built from full-adder cells; also exposes the
// carry into its MSB so the last stage can derive signed overflow.
module chunk_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        c_msb = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) begin
                c_msb = carry;
            end
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: each stage ripples one chunk and registers
// its carry; operands are skewed forward and finished sum chunks de-skewed to the output.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    generate
        if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
            $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
        end
    endgenerate

    logic             en;

    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic [WIDTH-1:0] opa_q   [STAGES];
    logic [WIDTH-1:0] opa_d   [STAGES];
    logic [WIDTH-1:0] opb_q   [STAGES];
    logic [WIDTH-1:0] opb_d   [STAGES];
    logic             ovf_q;
    logic             ovf_d;

    // Inputs seen by each stage: the port operands for stage 0, the previous register otherwise.
    logic             src_v   [STAGES];
    logic             src_c   [STAGES];
    logic [WIDTH-1:0] src_a   [STAGES];
    logic [WIDTH-1:0] src_b   [STAGES];
    logic [WIDTH-1:0] src_sum [STAGES];

    logic [CHUNK-1:0] chunk_sum  [STAGES];
    logic             chunk_cout [STAGES];
    logic             chunk_cmsb [STAGES];

    assign en       = ~valid_q[STAGES-1] | out_ready;
    assign in_ready = en;

    always_comb begin
        src_v[0]   = in_valid;
        src_c[0]   = sub ? 1'b1 : cin;
        src_a[0]   = a;
        src_b[0]   = sub ? ~b : b;
        src_sum[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]   = valid_q[k-1];
            src_c[k]   = carry_q[k-1];
            src_a[k]   = opa_q[k-1];
            src_b[k]   = opb_q[k-1];
            src_sum[k] = sum_q[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        chunk_adder #(
            .N (CHUNK)
        ) u_chunk (
            .a     (src_a[g][g*CHUNK +: CHUNK]),
            .b     (src_b[g][g*CHUNK +: CHUNK]),
            .cin   (src_c[g]),
            .sum   (chunk_sum[g]),
            .cout  (chunk_cout[g]),
            .c_msb (chunk_cmsb[g])
        );
    end

    // Bubbles advance like real data; only the global enable freezes the pipe.
    always_comb begin
        ovf_d = ovf_q;
        for (int k = 0; k < STAGES; k++) begin
            valid_d[k] = valid_q[k];
            carry_d[k] = carry_q[k];
            sum_d[k]   = sum_q[k];
            opa_d[k]   = opa_q[k];
            opb_d[k]   = opb_q[k];
        end
        if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_d[k]                  = src_v[k];
                carry_d[k]                  = chunk_cout[k];
                opa_d[k]                    = src_a[k];
                opb_d[k]                    = src_b[k];
                sum_d[k]                    = src_sum[k];
                sum_d[k][k*CHUNK +: CHUNK]  = chunk_sum[k];
            end
            ovf_d = chunk_cout[STAGES-1] ^ chunk_cmsb[STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                sum_q[k]   <= '0;
                opa_q[k]   <= '0;
                opb_q[k]   <= '0;
            end
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                carry_q[k] <= carry_d[k];
                sum_q[k]   <= sum_d[k];
                opa_q[k]   <= opa_d[k];
                opb_q[k]   <= opb_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign s         = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: random and directed operands against an arithmetic
// reference model, plus backpressure, mid-stream reset and a parameter sweep on carry chains.
module tb_pipelined_adder;

    localparam int W = 8;
    localparam int S = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, cin, sub;
    logic         out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, s;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
    );

    // Sweep instances: all-ones + 0 + carry-in must ripple through every stage.
    logic        sw_valid;
    logic [63:0] sw_a;
    logic        sw_ir0, sw_ir1, sw_ir2, sw_ir3;
    logic        sw_ov0, sw_ov1, sw_ov2, sw_ov3;
    logic        sw_co0, sw_co1, sw_co2, sw_co3;
    logic        sw_of0, sw_of1, sw_of2, sw_of3;
    logic [7:0]  sw_s0, sw_s1;
    logic [31:0] sw_s2;
    logic [63:0] sw_s3;

    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_sw0 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir0),
        .a(sw_a[7:0]), .b(8'h00), .cin(1'b1), .sub(1'b0),
        .out_valid(sw_ov0), .out_ready(1'b1), .s(sw_s0), .cout(sw_co0), .ovf(sw_of0));
    pipelined_adder #(.WIDTH(8), .STAGES(8)) u_sw1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir1),
        .a(sw_a[7:0]), .b(8'h00), .cin(1'b1), .sub(1'b0),
        .out_valid(sw_ov1), .out_ready(1'b1), .s(sw_s1), .cout(sw_co1), .ovf(sw_of1));
    pipelined_adder #(.WIDTH(32), .STAGES(4)) u_sw2 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir2),
        .a(sw_a[31:0]), .b(32'h0), .cin(1'b1), .sub(1'b0),
        .out_valid(sw_ov2), .out_ready(1'b1), .s(sw_s2), .cout(sw_co2), .ovf(sw_of2));
    pipelined_adder #(.WIDTH(64), .STAGES(8)) u_sw3 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir3),
        .a(sw_a), .b(64'h0), .cin(1'b1), .sub(1'b0),
        .out_valid(sw_ov3), .out_ready(1'b1), .s(sw_s3), .cout(sw_co3), .ovf(sw_of3));

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        int           acc;
        int           stalls;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   stalls = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands' unsigned and signed values.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic su);
        exp_t e;
        int ua, ub, sa, sb, r, sr;
        ua = int'(x);
        ub = int'(y);
        sa = int'($signed(x));
        sb = int'($signed(y));
        if (su) begin
            r      = ua - ub;
            sr     = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            r      = ua + ub + int'(ci);
            sr     = sa + sb + int'(ci);
            e.cout = (r >= (1 << W));
        end
        e.s      = r[W-1:0];
        e.ovf    = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
        e.acc    = 0;
        e.stalls = 0;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic su);
        exp_t e;
        bit   done;
        done     = 1'b0;
        a        = x;
        b        = y;
        cin      = ci;
        sub      = su;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            #1;
            if (in_ready) begin
                e        = model(x, y, ci, su);
                e.acc    = cyc + 1;
                e.stalls = stalls;
                q.push_back(e);
                done     = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles");
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && q.size() > 0; t++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
        end
    endtask

    // Monitor: pops on every output transfer; also checks hold-stability during stalls.
    initial begin
        exp_t         e;
        bit           was_stalled;
        logic [W-1:0] held_s;
        logic         held_c, held_o;
        was_stalled = 1'b0;
        held_s = '0;
        held_c = 1'b0;
        held_o = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid) begin
                if (!out_ready) begin
                    if (was_stalled) begin
                        chk("hold_s", s, held_s);
                        chk("hold_cout", cout, held_c);
                        chk("hold_ovf", ovf, held_o);
                    end
                    held_s      = s;
                    held_c      = cout;
                    held_o      = ovf;
                    was_stalled = 1'b1;
                    stalls++;
                end else begin
                    was_stalled = 1'b0;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: s=%0h with no operation outstanding", s);
                    end else begin
                        e = q.pop_front();
                        chk("sum", s, e.s);
                        chk("cout", cout, e.cout);
                        chk("ovf", ovf, e.ovf);
                        chk("latency", cyc + 1 - e.acc, S + (stalls - e.stalls));
                    end
                end
            end else begin
                was_stalled = 1'b0;
            end
            if (rst_n) chk("in_ready", in_ready, !out_valid || out_ready);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        sw_valid  = 1'b0;
        sw_a      = '0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors from the arithmetic corner cases.
        send(8'h0F, 8'h01, 1'b0, 1'b0);
        send(8'hFF, 8'h01, 1'b0, 1'b0);
        send(8'h05, 8'h07, 1'b0, 1'b1);
        send(8'h7F, 8'hFF, 1'b0, 1'b1);
        send(8'h7F, 8'h01, 1'b0, 1'b0);
        send(8'h05, 8'h07, 1'b1, 1'b1);
        send(8'h80, 8'h80, 1'b1, 1'b0);
        send(8'h00, 8'h00, 1'b0, 1'b1);
        drain();

        // Back-to-back random stream.
        for (int i = 0; i < 16; i++)
            send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        drain();

        // Fixed 5-cycle backpressure with the pipeline full.
        fork
            begin
                for (int i = 0; i < 12; i++)
                    send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            end
            begin
                repeat (6) @(negedge clk);
                out_ready = 1'b0;
                #1;
                chk("bp_in_ready", in_ready, 0);
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Random backpressure.
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            end
            begin
                for (int i = 0; i < 70; i++) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 2) != 0);
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with three operations in flight, the oldest stalled at the output.
        send(8'h11, 8'h22, 1'b0, 1'b0);
        send(8'h33, 8'h44, 1'b1, 1'b0);
        send(8'h55, 8'h01, 1'b0, 1'b1);
        out_ready = 1'b0;
        @(negedge clk);
        #3;
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_s", s, 0);
        chk("async_rst_cout", cout, 0);
        q.delete();
        repeat (2) @(negedge clk);
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        send(8'hA5, 8'h5A, 1'b1, 1'b0);
        drain();
        repeat (3) @(negedge clk);

        // Parameter sweep: carry ripples across the full width in every configuration.
        sw_a     = '1;
        sw_valid = 1'b1;
        @(negedge clk);
        sw_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #2;
            chk("sw_8_1_valid", sw_ov0, k == 0);
            chk("sw_8_8_valid", sw_ov1, k == 7);
            chk("sw_32_4_valid", sw_ov2, k == 3);
            chk("sw_64_8_valid", sw_ov3, k == 7);
            if (k == 0) begin
                chk("sw_8_1_s", sw_s0, 0);
                chk("sw_8_1_cout", sw_co0, 1);
            end
            if (k == 3) begin
                chk("sw_32_4_s", sw_s2, 0);
                chk("sw_32_4_cout", sw_co2, 1);
            end
            if (k == 7) begin
                chk("sw_8_8_s", sw_s1, 0);
                chk("sw_8_8_cout", sw_co1, 1);
                chk("sw_64_8_s", sw_s3, 0);
                chk("sw_64_8_cout", sw_co3, 1);
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
